qoi_decoder: RTL and testbench

Streaming QOI chunk decoder, the inverse of the design's QOI encoder: consumes the headerless QOI chunk byte stream the encoder produces and reconstructs the raster of RGBA pixels. It accepts one byte per handshake and emits one pixel per handshake. Its purpose is on-chip verification of the encoder via loopback (decoded pixels compared against the debayer output memory), and it serves as the front end of a future display path.

---
 rtl/qoi_decoder_if.sv | 24 ++
 rtl/qoi_decoder.sv | 144 ++++++++++++++
 tb/tb_qoi_decoder.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/qoi_decoder_if.sv
// Byte-in / pixel-out streaming bundle for the QOI chunk decoder.
// Both streams use valid/ready: a transfer happens on a rising edge where
// valid && ready; the producer holds data stable while valid is high and not accepted.
interface qoi_decoder_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] px_out;
  logic        px_valid;
  logic        px_ready;
  logic [15:0] pixel_count;
  logic        done;
  logic [2:0]  state_dbg;

  modport slave (
    input  byte_in, byte_valid, px_ready,
    output byte_ready, px_out, px_valid, pixel_count, done, state_dbg
  );

  modport master (
    output byte_in, byte_valid, px_ready,
    input  byte_ready, px_out, px_valid, pixel_count, done, state_dbg
  );
endinterface

// File: rtl/qoi_decoder.sv
// Streaming QOI chunk decoder: one byte per byte handshake, one RGBA pixel
// per pixel handshake, pixels packed {r,g,b,a}.
module qoi_decoder #(
  parameter int WIDTH  = 40,
  parameter int HEIGHT = 30
) (
  input logic          clk,
  input logic          reset,
  qoi_decoder_if.slave bus
);
  localparam logic [15:0] TOTAL = 16'(WIDTH * HEIGHT);

  typedef enum logic [2:0] {S_OPCODE, S_PAYLOAD, S_EMIT, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {M_RGB, M_RGBA, M_LUMA} mode_t;

  state_t      state, state_nx;
  mode_t       mode;
  logic [31:0] prev;
  logic [31:0] pix;
  logic [31:0] index_mem [64];
  logic [1:0]  pay_idx;
  logic [1:0]  pay_left;
  logic [5:0]  run_left;
  logic [7:0]  luma_dg;
  logic [15:0] pixel_count;
  logic        byte_fire;
  logic        px_fire;
  logic        last_px;
  logic [31:0] emit_px;

  function automatic logic [5:0] qoi_hash(input logic [31:0] p);
    logic [7:0] h;
    h = p[31:24] * 8'd3 + p[23:16] * 8'd5 + p[15:8] * 8'd7 + p[7:0] * 8'd11;
    return h[5:0];
  endfunction

  assign bus.byte_ready  = !reset && (state == S_OPCODE || state == S_PAYLOAD);
  assign bus.px_valid    = (state == S_EMIT) || (state == S_RUN);
  assign emit_px         = (state == S_RUN) ? prev : pix;
  assign bus.px_out      = bus.px_valid ? emit_px : 32'd0;
  assign bus.pixel_count = pixel_count;
  assign bus.done        = (state == S_DONE);
  assign bus.state_dbg   = state;

  assign byte_fire = bus.byte_valid && bus.byte_ready;
  assign px_fire   = bus.px_valid && bus.px_ready;
  assign last_px   = (pixel_count == TOTAL - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_OPCODE;
    else       state <= state_nx;
  end

  // FE/FF are tested before the 2-bit tag so 11111110/11111111 never decode as RUN.
  always_comb begin
    state_nx = state;
    case (state)
      S_OPCODE: if (byte_fire) begin
        if (bus.byte_in == 8'hFE || bus.byte_in == 8'hFF) state_nx = S_PAYLOAD;
        else begin
          case (bus.byte_in[7:6])
            2'b00, 2'b01: state_nx = S_EMIT;
            2'b10:        state_nx = S_PAYLOAD;
            default:      state_nx = S_RUN;
          endcase
        end
      end
      S_PAYLOAD: if (byte_fire && pay_left == 2'd0) state_nx = S_EMIT;
      S_EMIT:    if (px_fire) state_nx = last_px ? S_DONE : S_OPCODE;
      S_RUN:     if (px_fire) begin
        if (last_px)                state_nx = S_DONE;
        else if (run_left == 6'd0)  state_nx = S_OPCODE;
      end
      default:   state_nx = S_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev        <= 32'h000000FF;
      pix         <= 32'd0;
      mode        <= M_RGB;
      pay_idx     <= 2'd0;
      pay_left    <= 2'd0;
      run_left    <= 6'd0;
      luma_dg     <= 8'd0;
      pixel_count <= 16'd0;
      for (int i = 0; i < 64; i++) index_mem[i] <= 32'd0;
    end else begin
      case (state)
        S_OPCODE: if (byte_fire) begin
          pay_idx <= 2'd0;
          if (bus.byte_in == 8'hFE) begin
            mode     <= M_RGB;
            pay_left <= 2'd2;
            pix      <= prev;
          end else if (bus.byte_in == 8'hFF) begin
            mode     <= M_RGBA;
            pay_left <= 2'd3;
            pix      <= prev;
          end else begin
            case (bus.byte_in[7:6])
              2'b00: pix <= index_mem[bus.byte_in[5:0]];
              2'b01: pix <= {prev[31:24] + {6'd0, bus.byte_in[5:4]} - 8'd2,
                             prev[23:16] + {6'd0, bus.byte_in[3:2]} - 8'd2,
                             prev[15:8]  + {6'd0, bus.byte_in[1:0]} - 8'd2,
                             prev[7:0]};
              2'b10: begin
                mode     <= M_LUMA;
                pay_left <= 2'd0;
                luma_dg  <= {2'b00, bus.byte_in[5:0]} - 8'd32;
              end
              default: run_left <= bus.byte_in[5:0];
            endcase
          end
        end
        S_PAYLOAD: if (byte_fire) begin
          pay_left <= pay_left - 2'd1;
          pay_idx  <= pay_idx + 2'd1;
          if (mode == M_LUMA) begin
            pix <= {prev[31:24] + luma_dg + {4'd0, bus.byte_in[7:4]} - 8'd8,
                    prev[23:16] + luma_dg,
                    prev[15:8]  + luma_dg + {4'd0, bus.byte_in[3:0]} - 8'd8,
                    prev[7:0]};
          end else begin
            case (pay_idx)
              2'd0:    pix[31:24] <= bus.byte_in;
              2'd1:    pix[23:16] <= bus.byte_in;
              2'd2:    pix[15:8]  <= bus.byte_in;
              default: pix[7:0]   <= bus.byte_in;
            endcase
          end
        end
        S_EMIT, S_RUN: if (px_fire) begin
          prev                       <= emit_px;
          index_mem[qoi_hash(emit_px)] <= emit_px;
          pixel_count                <= pixel_count + 16'd1;
          if (state == S_RUN) run_left <= run_left - 6'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_qoi_decoder.sv
// Directed bench for qoi_decoder: a 40x30 instance for chunk decoding and a
// 2x2 instance for frame-end truncation and mid-run reset.
module tb_qoi_decoder;
  logic clk;
  logic rst;
  logic rst_s;
  int   total_cnt;
  int   bad_cnt;
  logic [31:0] exp_q[$];

  qoi_decoder_if mb();
  qoi_decoder_if sb();

  qoi_decoder #(.WIDTH(40), .HEIGHT(30)) dut (.clk(clk), .reset(rst), .bus(mb));
  qoi_decoder #(.WIDTH(2), .HEIGHT(2)) dut_s (.clk(clk), .reset(rst_s), .bus(sb));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input bit sm);
    @(negedge clk);
    if (sm) rst_s = 1'b1; else rst = 1'b1;
    @(negedge clk);
    if (sm) rst_s = 1'b0; else rst = 1'b0;
  endtask

  // driver tasks
  task automatic send_byte(input bit sm, input logic [7:0] b);
    int   n;
    logic rdy;
    @(negedge clk);
    if (sm) begin sb.byte_in = b; sb.byte_valid = 1'b1; end
    else    begin mb.byte_in = b; mb.byte_valid = 1'b1; end
    n   = 0;
    rdy = sm ? sb.byte_ready : mb.byte_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
      rdy = sm ? sb.byte_ready : mb.byte_ready;
    end
    if (n >= 20) check("byte_accept_timeout", {31'd0, rdy}, 32'd1);
    @(posedge clk);
    #1;
    if (sm) sb.byte_valid = 1'b0; else mb.byte_valid = 1'b0;
  endtask

  task automatic recv_px(input bit sm, output logic [31:0] px);
    int   n;
    logic vld;
    @(negedge clk);
    if (sm) sb.px_ready = 1'b1; else mb.px_ready = 1'b1;
    n   = 0;
    vld = sm ? sb.px_valid : mb.px_valid;
    while (!vld && n < 20) begin
      @(negedge clk);
      n++;
      vld = sm ? sb.px_valid : mb.px_valid;
    end
    if (n >= 20) check("px_valid_timeout", {31'd0, vld}, 32'd1);
    px = sm ? sb.px_out : mb.px_out;
    @(posedge clk);
    #1;
    if (sm) sb.px_ready = 1'b0; else mb.px_ready = 1'b0;
  endtask

  // scoreboard: pop the next expected pixel and compare
  task automatic expect_px(input bit sm, input string tag);
    logic [31:0] got;
    logic [31:0] exp;
    recv_px(sm, got);
    if (exp_q.size() == 0) check({tag, "_noexp"}, got, 32'hxxxxxxxx);
    else begin
      exp = exp_q.pop_front();
      check(tag, got, exp);
    end
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst = 1'b1; rst_s = 1'b1;
    mb.byte_in = 8'd0; mb.byte_valid = 1'b0; mb.px_ready = 1'b0;
    sb.byte_in = 8'd0; sb.byte_valid = 1'b0; sb.px_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_px_out",  mb.px_out, 32'd0);
    check("rst_px_valid", {31'd0, mb.px_valid}, 32'd0);
    check("rst_count",   {16'd0, mb.pixel_count}, 32'd0);
    check("rst_done",    {31'd0, mb.done}, 32'd0);
    check("rst_byte_ready", {31'd0, mb.byte_ready}, 32'd0);
    rst = 1'b0; rst_s = 1'b0;
    @(negedge clk);
    check("post_rst_byte_ready", {31'd0, mb.byte_ready}, 32'd1);

    // RGB chunk, one-cycle latency
    send_byte(0, 8'hFE); send_byte(0, 8'h10); send_byte(0, 8'h20); send_byte(0, 8'h30);
    @(negedge clk);
    check("rgb_latency_valid", {31'd0, mb.px_valid}, 32'd1);
    exp_q.push_back(32'h102030FF);
    expect_px(0, "rgb_px");
    check("rgb_count", {16'd0, mb.pixel_count}, 32'd1);

    // DIFF +1 on all colour channels
    send_byte(0, 8'h7F);
    exp_q.push_back(32'h112131FF);
    expect_px(0, "diff_plus");

    // DIFF -2 wrapping below zero
    do_reset(0);
    send_byte(0, 8'h40);
    exp_q.push_back(32'hFEFEFEFF);
    expect_px(0, "diff_wrap");

    // LUMA, then INDEX hit at hash 21
    do_reset(0);
    send_byte(0, 8'hFE); send_byte(0, 8'h10); send_byte(0, 8'h20); send_byte(0, 8'h30);
    exp_q.push_back(32'h102030FF);
    expect_px(0, "rgb_seed");
    send_byte(0, 8'hA8); send_byte(0, 8'h88);
    exp_q.push_back(32'h182838FF);
    expect_px(0, "luma");
    send_byte(0, 8'hFE); send_byte(0, 8'h00); send_byte(0, 8'h00); send_byte(0, 8'h00);
    exp_q.push_back(32'h000000FF);
    expect_px(0, "rgb_black");
    send_byte(0, 8'h15);
    exp_q.push_back(32'h102030FF);
    expect_px(0, "index_21");
    check("count_before_run", {16'd0, mb.pixel_count}, 32'd4);

    // RUN of 5 with backpressure
    send_byte(0, 8'hC4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("run_hold_valid", {31'd0, mb.px_valid}, 32'd1);
      check("run_hold_px", mb.px_out, 32'h102030FF);
      check("run_hold_byte_ready", {31'd0, mb.byte_ready}, 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(32'h102030FF);
      expect_px(0, "run_px");
      if (i < 4) check("run_byte_ready", {31'd0, mb.byte_ready}, 32'd0);
    end
    check("run_end_byte_ready", {31'd0, mb.byte_ready}, 32'd1);
    check("run_count", {16'd0, mb.pixel_count}, 32'd9);

    // 2x2 frame: run truncated at the frame end
    send_byte(1, 8'hFE); send_byte(1, 8'h01); send_byte(1, 8'h02); send_byte(1, 8'h03);
    exp_q.push_back(32'h010203FF);
    expect_px(1, "s_rgb");
    send_byte(1, 8'hFD);
    for (int i = 0; i < 3; i++) begin
      check("s_not_done_yet", {31'd0, sb.done}, 32'd0);
      exp_q.push_back(32'h010203FF);
      expect_px(1, "s_run_px");
    end
    check("s_done", {31'd0, sb.done}, 32'd1);
    check("s_done_px_valid", {31'd0, sb.px_valid}, 32'd0);
    check("s_done_count", {16'd0, sb.pixel_count}, 32'd4);
    check("s_done_state", {29'd0, sb.state_dbg}, 32'd4);
    @(negedge clk);
    sb.byte_in = 8'h7F; sb.byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s_done_byte_ready", {31'd0, sb.byte_ready}, 32'd0);
      check("s_done_px_valid_hold", {31'd0, sb.px_valid}, 32'd0);
    end
    sb.byte_valid = 1'b0;
    check("s_done_count_hold", {16'd0, sb.pixel_count}, 32'd4);

    // reset asserted mid-run
    do_reset(1);
    send_byte(1, 8'hFE); send_byte(1, 8'h01); send_byte(1, 8'h02); send_byte(1, 8'h03);
    exp_q.push_back(32'h010203FF);
    expect_px(1, "s2_rgb");
    send_byte(1, 8'hC5);
    exp_q.push_back(32'h010203FF);
    expect_px(1, "s2_run_px");
    @(negedge clk);
    check("s2_midrun_valid", {31'd0, sb.px_valid}, 32'd1);
    rst_s = 1'b1;
    #1;
    check("s2_rst_px_valid", {31'd0, sb.px_valid}, 32'd0);
    check("s2_rst_px_out", sb.px_out, 32'd0);
    check("s2_rst_count", {16'd0, sb.pixel_count}, 32'd0);
    check("s2_rst_done", {31'd0, sb.done}, 32'd0);
    check("s2_rst_byte_ready", {31'd0, sb.byte_ready}, 32'd0);
    @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
    check("s2_after_rst_ready", {31'd0, sb.byte_ready}, 32'd1);
    check("s2_after_rst_valid", {31'd0, sb.px_valid}, 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
